comp_sweep_checker: RTL
=======================

// Module: comp_sweep_checker
// PURPOSE
//  Drives X/Y operand pairs into a combinational magnitude comparator (LG/EQ/SM
//  outputs, one-hot) and checks the responses in hardware. Sweeps all 2^(2*W)
//  pairs, X fastest and Y outer. Reports error count, first failing pair and a
//  pass flag. This is the stimulus/checker end of the comparator interface, for
//  on-board self-test of comparator instances.
// PARAMETERS
//  W      2  operand width in bits (>=1)
//  SETTLE 2  clock cycles between driving a pair and sampling it (>=1)
//  ERR_W  8  width of the saturating error counter (>=1)
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      asynchronous, active-high reset
//  start       in   1      one-cycle pulse; sampled only in IDLE or DONE
//  x_out       out  W      operand X to comparator
//  y_out       out  W      operand Y to comparator
//  lg_in       in   1      comparator result X>Y
//  eq_in       in   1      comparator result X==Y
//  sm_in       in   1      comparator result X<Y
//  busy        out  1      high while sweeping (WAIT or CHECK)
//  done        out  1      high in DONE; held until start or rst
//  pass        out  1      done && err_cnt==0
//  err_cnt     out  ERR_W  mismatching pairs, saturates at 2^ERR_W-1
//  first_vld   out  1      at least one mismatch recorded this run
//  first_x     out  W      X of first mismatch (0 if none)
//  first_y     out  W      Y of first mismatch (0 if none)
// BEHAVIOUR
//  Reset (async, any state): state=IDLE. All outputs are 0. Settle counter is 0.
//  FSM states: IDLE, WAIT, CHECK, DONE.
//   IDLE : start=1 -> WAIT. Load x_out=0, y_out=0, settle cnt=0, err_cnt=0,
//          first_vld=0, first_x=0, first_y=0.
//   WAIT : settle cnt increments each cycle. When cnt==SETTLE-1, go to CHECK and
//          clear cnt. x_out and y_out are held stable.
//   CHECK: sample lg_in/eq_in/sm_in on this edge. Expected value is
//          {x_out>y_out, x_out==y_out, x_out<y_out}, compared unsigned.
//          Any difference is a mismatch; non-one-hot responses are always one.
//          On mismatch: err_cnt+1, saturating. If first_vld==0, latch
//          first_x/first_y from x_out/y_out and set first_vld=1.
//          If x_out==all-ones and y_out==all-ones -> DONE.
//          Otherwise -> WAIT with x_out+1. On X wrap (all-ones->0), y_out+1.
//   DONE : done=1, busy=0. start=1 -> same restart as from IDLE, and done
//          drops on that edge.
//  start while busy is ignored; it neither restarts nor queues.
//  Timing: the edge sampling start is edge k. Pair i (i=x+y*2^W) is checked at
//   edge k+(i+1)*(SETTLE+1). done rises after edge k+2^(2W)*(SETTLE+1).
//   Defaults give 48 cycles.
//  busy=1 exactly in WAIT/CHECK. done and busy are never both high.
//  Results (err_cnt, first_*, pass) stay stable in DONE until restart or rst.
//  Inputs lg/eq/sm are treated as synchronous to clk. No synchronizers.
// TESTING
//  T1 correct comparator model, defaults, start at edge k -> done after edge
//     k+48, err_cnt=0, pass=1, first_vld=0. x/y visit (0,0),(1,0)..(3,3) in order.
//  T2 model with eq_in stuck 0 -> err_cnt=4, first_vld=1, first_x=0,
//     first_y=0, pass=0.
//  T3 model with lg/sm swapped -> err_cnt=12, first_x=1, first_y=0.
//  T4 start pulsed mid-sweep (edge k+10) -> ignored, done still after k+48.
//     start in DONE -> done=0 next cycle, err_cnt cleared, full rerun passes.
//  T5 rst asserted between edges mid-sweep (~k+20) -> outputs 0 immediately,
//     before next edge. After release, state IDLE. A new start completes with
//     pass=1.
//  T6 W=3, ERR_W=3, all responses 0 -> err_cnt saturates at 7 (64 mismatches),
//     first_x=0, first_y=0. done after 192 cycles.

Source files
------------

// File: rtl/comp_sweep_checker.sv
// ---------------------------------------------------------------------------
// comp_sweep_checker
//
// Purpose:
//   This module is the stimulus and checker end of a comparator interface. It
//   sends every X/Y operand pair to an external combinational magnitude
//   comparator and checks the one-hot LG/EQ/SM response in hardware. X changes
//   fastest and Y is the outer loop. The module reports a saturating error
//   count, the first failing pair and a pass flag. It is used for on-board
//   self-test of comparator instances.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   start      in   one-cycle start pulse (see handshake note below)
//   x_out      out  [W-1:0]     operand X driven to the comparator
//   y_out      out  [W-1:0]     operand Y driven to the comparator
//   lg_in      in   comparator result X>Y
//   eq_in      in   comparator result X==Y
//   sm_in      in   comparator result X<Y
//   busy       out  high while sweeping (WAIT or CHECK)
//   done       out  high in DONE, held until restart or reset
//   pass       out  done && err_cnt==0
//   err_cnt    out  [ERR_W-1:0] mismatching pairs, saturating
//   first_vld  out  at least one mismatch recorded this run
//   first_x    out  [W-1:0]     X of first mismatch (0 if none)
//   first_y    out  [W-1:0]     Y of first mismatch (0 if none)
//   state_dbg  out  [1:0]       current FSM state (IDLE=0 WAIT=1 CHECK=2 DONE=3)
//
// Handshake: start acts as a valid with an implicit ready of !busy. A start
// seen while busy is low (IDLE or DONE) is accepted on that edge. A start
// seen while busy is high is dropped. It is never queued.
// ---------------------------------------------------------------------------
module comp_sweep_checker #(
  parameter int W      = 2,
  parameter int SETTLE = 2,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [W-1:0]     x_out,
  output logic [W-1:0]     y_out,
  input  logic             lg_in,
  input  logic             eq_in,
  input  logic             sm_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             first_vld,
  output logic [W-1:0]     first_x,
  output logic [W-1:0]     first_y,
  output logic [1:0]       state_dbg
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [W-1:0]     ALL_ONES = '1;
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       exp_resp;
  logic             mismatch;
  logic             load;
  logic             settle_end;
  logic             last_pair;

  // The expected response is always one-hot. A non-one-hot reply therefore
  // never matches it and is counted as a mismatch automatically.
  assign exp_resp   = {x_out > y_out, x_out == y_out, x_out < y_out};
  assign mismatch   = ({lg_in, eq_in, sm_in} != exp_resp);
  assign settle_end = (cnt_q == CNT_LAST);
  assign last_pair  = (x_out == ALL_ONES) && (y_out == ALL_ONES);
  assign load       = start && ((state_q == IDLE) || (state_q == DONE));

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (start) state_nxt = WAIT;
      WAIT:    if (settle_end) state_nxt = CHECK;
      CHECK:   state_nxt = last_pair ? DONE : WAIT;
      DONE:    if (start) state_nxt = WAIT;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand, settle-counter and result datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_out     <= '0;
      y_out     <= '0;
      cnt_q     <= '0;
      err_cnt   <= '0;
      first_vld <= 1'b0;
      first_x   <= '0;
      first_y   <= '0;
    end else if (load) begin
      x_out     <= '0;
      y_out     <= '0;
      cnt_q     <= '0;
      err_cnt   <= '0;
      first_vld <= 1'b0;
      first_x   <= '0;
      first_y   <= '0;
    end else begin
      case (state_q)
        WAIT: begin
          if (settle_end) begin
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        CHECK: begin
          if (mismatch) begin
            if (err_cnt != ERR_MAX) begin
              err_cnt <= err_cnt + ERR_W'(1);
            end
            if (!first_vld) begin
              first_vld <= 1'b1;
              first_x   <= x_out;
              first_y   <= y_out;
            end
          end
          // On the last pair the operands are held, so they stay visible in DONE.
          if (!last_pair) begin
            x_out <= x_out + W'(1);
            if (x_out == ALL_ONES) begin
              y_out <= y_out + W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q == WAIT) || (state_q == CHECK);
  assign done      = (state_q == DONE);
  assign pass      = done && (err_cnt == '0);
  assign state_dbg = state_q;

endmodule
